// File: rtl/chimera_pkg.sv
// Shared types and default constants for the cluster power sequencer.
// Ports: none (package only).
// Holds the sequencer state enum and the default cycle counts.
package chimera_pkg;

  localparam int ExtClusters     = 5;
  localparam int CluRstCycles    = 8;
  localparam int CluSettleCycles = 4;
  localparam int CluDrainTimeout = 255;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UP_RST    = 3'd1,
    UP_SETTLE = 3'd2,
    UP_DONE   = 3'd3,
    DN_ISO    = 3'd4,
    DN_DRAIN  = 3'd5,
    DN_RST    = 3'd6,
    DN_CLK    = 3'd7
  } clu_seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/chimera_clu_pwr_sequencer_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// Ports: clk/rst, req vector, take (grant consumed), gnt_vld/gnt_idx.
// Grant is combinational; the pointer moves past the granted index only on take.
module chimera_clu_pwr_sequencer_rr_arb #(
  parameter int NumIn = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NumIn-1:0]         req,
  input  logic                     take,
  output logic                     gnt_vld,
  output logic [$clog2(NumIn)-1:0] gnt_idx
);

  localparam int IdxW = $clog2(NumIn);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand_idx;
  int              cand;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NumIn; off++) begin
      cand     = (int'(ptr_q) + off) % NumIn;
      cand_idx = IdxW'(cand);
      if (!gnt_vld && req[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (take && gnt_vld) begin
      ptr_q <= (gnt_idx == IdxW'(NumIn - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/chimera_clu_pwr_sequencer.sv
// Sequences clock enable, reset, AXI isolation and widemem bypass per external cluster.
// Ports: soc_clk_i/rst_i; en_req/bypass_cfg/clu_busy/clr_timeout in; per-cluster controls,
// status (clu_on, timeout) and sequencer state (seq_busy, seq_idx) out, all registered.
module chimera_clu_pwr_sequencer
  import chimera_pkg::*;
#(
  parameter int NumClusters  = ExtClusters,  // must be >= 2
  parameter int RstCycles    = CluRstCycles,
  parameter int SettleCycles = CluSettleCycles,
  parameter int DrainTimeout = CluDrainTimeout
) (
  input  logic                           soc_clk_i,
  input  logic                           rst_i,
  input  logic [NumClusters-1:0]         en_req_i,
  input  logic [NumClusters-1:0]         bypass_cfg_i,
  input  logic [NumClusters-1:0]         clu_busy_i,
  input  logic                           clr_timeout_i,
  output logic [NumClusters-1:0]         clu_clk_en_o,
  output logic [NumClusters-1:0]         clu_rst_no,
  output logic [NumClusters-1:0]         clu_isolate_o,
  output logic [NumClusters-1:0]         widemem_bypass_o,
  output logic [NumClusters-1:0]         clu_on_o,
  output logic                           seq_busy_o,
  output logic [$clog2(NumClusters)-1:0] seq_idx_o,
  output logic [NumClusters-1:0]         timeout_o
);

  localparam int IdxW = $clog2(NumClusters);
  localparam int CntW = $clog2(max3(RstCycles, SettleCycles, DrainTimeout) + 1);

  localparam logic [CntW-1:0] RstLoad    = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] DrainLoad  = CntW'(DrainTimeout);

  clu_seq_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NumClusters-1:0] clk_en_d, rst_n_d, iso_d, byp_d, on_d, tmo_d;
  logic [IdxW-1:0]        idx_d;
  logic                   busy_d;

  logic [NumClusters-1:0] arb_req;
  logic                   arb_take;
  logic                   gnt_vld;
  logic [IdxW-1:0]        gnt_idx;

  // Only look for new work while idle; requests changing mid-sequence wait for IDLE.
  assign arb_req = (en_req_i ^ clu_on_o) & {NumClusters{state_q == IDLE}};

  chimera_clu_pwr_sequencer_rr_arb #(
    .NumIn(NumClusters)
  ) u_arb (
    .clk    (soc_clk_i),
    .rst    (rst_i),
    .req    (arb_req),
    .take   (arb_take),
    .gnt_vld(gnt_vld),
    .gnt_idx(gnt_idx)
  );

  // Outputs are computed as the value they take on entry to the next state,
  // so every control change lands exactly on the state transition edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arb_take = 1'b0;
    idx_d    = seq_idx_o;
    clk_en_d = clu_clk_en_o;
    rst_n_d  = clu_rst_no;
    iso_d    = clu_isolate_o;
    byp_d    = widemem_bypass_o;
    on_d     = clu_on_o;
    // A timeout set below overrides a coincident clear.
    tmo_d    = timeout_o & ~{NumClusters{clr_timeout_i}};

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          arb_take = 1'b1;
          idx_d    = gnt_idx;
          if (en_req_i[gnt_idx]) begin
            state_d           = UP_RST;
            cnt_d             = RstLoad;
            clk_en_d[gnt_idx] = 1'b1;
            rst_n_d[gnt_idx]  = 1'b0;
            byp_d[gnt_idx]    = bypass_cfg_i[gnt_idx];
          end else begin
            state_d        = DN_ISO;
            cnt_d          = '0;
            iso_d[gnt_idx] = 1'b1;
            on_d[gnt_idx]  = 1'b0;
          end
        end
      end
      UP_RST: begin
        if (cnt_q == '0) begin
          state_d            = UP_SETTLE;
          cnt_d              = SettleLoad;
          rst_n_d[seq_idx_o] = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      UP_SETTLE: begin
        if (cnt_q == '0) begin
          state_d          = UP_DONE;
          cnt_d            = '0;
          iso_d[seq_idx_o] = 1'b0;
          on_d[seq_idx_o]  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      UP_DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      DN_ISO: begin
        state_d = DN_DRAIN;
        cnt_d   = DrainLoad;
      end
      DN_DRAIN: begin
        // cnt_q == 1 marks the last of DrainTimeout cycles spent here.
        if (!clu_busy_i[seq_idx_o] || cnt_q == CntW'(1)) begin
          state_d            = DN_RST;
          cnt_d              = RstLoad;
          rst_n_d[seq_idx_o] = 1'b0;
          if (clu_busy_i[seq_idx_o]) tmo_d[seq_idx_o] = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DN_RST: begin
        if (cnt_q == '0) begin
          state_d             = DN_CLK;
          cnt_d               = '0;
          clk_en_d[seq_idx_o] = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DN_CLK: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge soc_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      clu_clk_en_o     <= '0;
      clu_rst_no       <= '0;
      clu_isolate_o    <= '1;
      widemem_bypass_o <= '0;
      clu_on_o         <= '0;
      seq_busy_o       <= 1'b0;
      seq_idx_o        <= '0;
      timeout_o        <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      clu_clk_en_o     <= clk_en_d;
      clu_rst_no       <= rst_n_d;
      clu_isolate_o    <= iso_d;
      widemem_bypass_o <= byp_d;
      clu_on_o         <= on_d;
      seq_busy_o       <= busy_d;
      seq_idx_o        <= idx_d;
      timeout_o        <= tmo_d;
    end
  end

endmodule

// File: tb/tb_chimera_clu_pwr_sequencer.sv
// Directed bench for the cluster power sequencer (default parameters).
// Ports: none; drives the DUT on soc_clk_i and samples 1 time unit after each rising edge.
// Each scenario task checks its own hand-computed cycle-exact expectations.
module tb_chimera_clu_pwr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] en_req, bypass_cfg, clu_busy;
  logic       clr;
  logic [4:0] clk_en, rst_n, iso, byp, on, tmo;
  logic       busy;
  logic [2:0] idx;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  chimera_clu_pwr_sequencer dut (
    .soc_clk_i       (clk),
    .rst_i           (rst),
    .en_req_i        (en_req),
    .bypass_cfg_i    (bypass_cfg),
    .clu_busy_i      (clu_busy),
    .clr_timeout_i   (clr),
    .clu_clk_en_o    (clk_en),
    .clu_rst_no      (rst_n),
    .clu_isolate_o   (iso),
    .widemem_bypass_o(byp),
    .clu_on_o        (on),
    .seq_busy_o      (busy),
    .seq_idx_o       (idx),
    .timeout_o       (tmo)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en_req = '0; bypass_cfg = '0; clu_busy = '0; clr = 1'b0;
    tick(2);
    vecs++; if ({clk_en, rst_n, on, byp, tmo} !== 25'd0) begin errs++;
      $display("FAIL rst_zero: got %b want 0", {clk_en, rst_n, on, byp, tmo}); end
    vecs++; if (iso !== 5'b11111) begin errs++; $display("FAIL rst_iso: got %b want 11111", iso); end
    vecs++; if ({busy, idx} !== 4'd0) begin errs++; $display("FAIL rst_busy_idx: got %b want 0000", {busy, idx}); end
    rst = 1'b0;
    tick(2);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_after_rst: got %b want 0", busy); end
  endtask

  // 10011 from all-off: clusters 0,1,4 each take a 13-cycle sequence plus one IDLE cycle.
  task automatic test_concurrent;
    en_req = 5'b10011;
    tick(1);   // t+1
    vecs++; if ({busy, idx, clk_en} !== {1'b1, 3'd0, 5'b00001}) begin errs++;
      $display("FAIL conc_first: got %b want 1_000_00001", {busy, idx, clk_en}); end
    tick(12);  // t+13
    vecs++; if (on !== 5'b00001) begin errs++; $display("FAIL conc_on0: got %b want 00001", on); end
    tick(1);   // t+14
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL conc_gap: got %b want 0", busy); end
    tick(1);   // t+15
    vecs++; if ({busy, idx} !== {1'b1, 3'd1}) begin errs++; $display("FAIL conc_second: got %b want 1_001", {busy, idx}); end
    tick(12);  // t+27
    vecs++; if (on !== 5'b00011) begin errs++; $display("FAIL conc_on1: got %b want 00011", on); end
    tick(2);   // t+29
    vecs++; if ({busy, idx} !== {1'b1, 3'd4}) begin errs++; $display("FAIL conc_third: got %b want 1_100", {busy, idx}); end
    tick(12);  // t+41
    vecs++; if ({busy, on} !== {1'b1, 5'b10011}) begin errs++; $display("FAIL conc_on4: got %b want 1_10011", {busy, on}); end
    tick(1);   // t+42
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL conc_end: got %b want 0", busy); end
  endtask

  task automatic test_power_up;
    bypass_cfg = 5'b00100;
    en_req     = 5'b10111;
    tick(1);   // t+1
    vecs++; if ({clk_en[2], rst_n[2], idx, byp} !== {1'b1, 1'b0, 3'd2, 5'b00100}) begin errs++;
      $display("FAIL up_t1: got %b want 1_0_010_00100", {clk_en[2], rst_n[2], idx, byp}); end
    tick(7);   // t+8
    vecs++; if (rst_n[2] !== 1'b0) begin errs++; $display("FAIL up_t8_rst: got %b want 0", rst_n[2]); end
    tick(1);   // t+9
    vecs++; if ({rst_n[2], iso[2]} !== 2'b11) begin errs++; $display("FAIL up_t9: got %b want 11", {rst_n[2], iso[2]}); end
    tick(3);   // t+12
    vecs++; if ({iso[2], on[2]} !== 2'b10) begin errs++; $display("FAIL up_t12: got %b want 10", {iso[2], on[2]}); end
    tick(1);   // t+13
    vecs++; if ({iso, on} !== {5'b01000, 5'b10111}) begin errs++;
      $display("FAIL up_t13: got %b want 01000_10111", {iso, on}); end
    tick(1);   // t+14
  endtask

  task automatic test_drain;
    clu_busy = 5'b00010;
    en_req   = 5'b10101;
    tick(1);   // t+1
    vecs++; if ({iso[1], on[1], clk_en[1]} !== 3'b101) begin errs++;
      $display("FAIL dn_iso: got %b want 101", {iso[1], on[1], clk_en[1]}); end
    tick(19);  // t+20
    vecs++; if (rst_n[1] !== 1'b1) begin errs++; $display("FAIL dn_draining: got %b want 1", rst_n[1]); end
    clu_busy = '0;
    tick(1);   // t+21
    vecs++; if ({rst_n[1], clk_en[1]} !== 2'b01) begin errs++; $display("FAIL dn_rst: got %b want 01", {rst_n[1], clk_en[1]}); end
    tick(7);   // t+28
    vecs++; if (clk_en[1] !== 1'b1) begin errs++; $display("FAIL dn_clk_early: got %b want 1", clk_en[1]); end
    tick(1);   // t+29
    vecs++; if ({clk_en[1], tmo[1]} !== 2'b00) begin errs++; $display("FAIL dn_clk: got %b want 00", {clk_en[1], tmo[1]}); end
    tick(1);   // t+30
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL dn_done: got %b want 0", busy); end
  endtask

  task automatic test_timeout;
    en_req = 5'b11101;
    tick(14);
    vecs++; if (on !== 5'b11101) begin errs++; $display("FAIL to_up3: got %b want 11101", on); end
    clu_busy = 5'b01000;
    en_req   = 5'b10101;
    tick(1);   // t+1
    vecs++; if ({iso[3], on[3]} !== 2'b10) begin errs++; $display("FAIL to_iso: got %b want 10", {iso[3], on[3]}); end
    tick(255); // t+256: last drain cycle
    vecs++; if ({tmo, rst_n[3]} !== 6'b000001) begin errs++; $display("FAIL to_pre: got %b want 00000_1", {tmo, rst_n[3]}); end
    clr = 1'b1;  // coincides with the timeout set; set must win
    tick(1);   // t+257
    clr = 1'b0;
    vecs++; if ({tmo, rst_n[3]} !== 6'b010000) begin errs++; $display("FAIL to_set: got %b want 01000_0", {tmo, rst_n[3]}); end
    tick(7);   // t+264
    vecs++; if (clk_en[3] !== 1'b1) begin errs++; $display("FAIL to_clk_early: got %b want 1", clk_en[3]); end
    tick(1);   // t+265
    vecs++; if (clk_en[3] !== 1'b0) begin errs++; $display("FAIL to_clk: got %b want 0", clk_en[3]); end
    tick(1);   // t+266
    clu_busy = '0;
    vecs++; if ({busy, tmo} !== {1'b0, 5'b01000}) begin errs++; $display("FAIL to_sticky: got %b want 0_01000", {busy, tmo}); end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    vecs++; if (tmo !== 5'b00000) begin errs++; $display("FAIL to_clear: got %b want 00000", tmo); end
  endtask

  task automatic test_bypass;
    bypass_cfg = 5'b11011;
    tick(3);
    vecs++; if (byp !== 5'b00100) begin errs++; $display("FAIL byp_stable_on: got %b want 00100", byp); end
    bypass_cfg = 5'b00000;
    tick(2);
    vecs++; if (byp !== 5'b00100) begin errs++; $display("FAIL byp_stable_toggle: got %b want 00100", byp); end
    bypass_cfg = 5'b11011;
    en_req = 5'b10100;    // power cl0 down, busy low
    tick(3);   // t+3
    vecs++; if (rst_n[0] !== 1'b0) begin errs++; $display("FAIL byp_dn_rst: got %b want 0", rst_n[0]); end
    tick(8);   // t+11
    vecs++; if ({clk_en[0], byp} !== {1'b0, 5'b00100}) begin errs++; $display("FAIL byp_dn_clk: got %b want 0_00100", {clk_en[0], byp}); end
    tick(1);   // t+12
    en_req = 5'b10101;
    tick(1);
    vecs++; if ({idx, byp} !== {3'd0, 5'b00101}) begin errs++; $display("FAIL byp_latch: got %b want 000_00101", {idx, byp}); end
    tick(13);
    vecs++; if (on !== 5'b10101) begin errs++; $display("FAIL byp_up: got %b want 10101", on); end
  endtask

  task automatic test_mid_reset;
    en_req = 5'b11101;
    tick(10);  // t+10, cl3 in UP_SETTLE
    vecs++; if ({idx, rst_n[3], iso[3]} !== {3'd3, 2'b11}) begin errs++; $display("FAIL mr_settle: got %b want 011_11", {idx, rst_n[3], iso[3]}); end
    rst = 1'b1;
    #1;
    vecs++; if ({clk_en, rst_n, on, byp, tmo, busy, idx} !== 29'd0) begin errs++;
      $display("FAIL mr_zero: got %b want 0", {clk_en, rst_n, on, byp, tmo, busy, idx}); end
    vecs++; if (iso !== 5'b11111) begin errs++; $display("FAIL mr_iso: got %b want 11111", iso); end
    tick(1);
    rst = 1'b0;
    tick(1);
    vecs++; if ({busy, idx, clk_en, rst_n} !== {1'b1, 3'd0, 5'b00001, 5'b00000}) begin errs++;
      $display("FAIL mr_restart: got %b want 1_000_00001_00000", {busy, idx, clk_en, rst_n}); end
    tick(12);
    vecs++; if (on !== 5'b00001) begin errs++; $display("FAIL mr_on0: got %b want 00001", on); end
  endtask

  initial begin
    test_reset();
    test_concurrent();
    test_power_up();
    test_drain();
    test_timeout();
    test_bypass();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
